// File: rtl/rv32i_pkg.sv
// Shared RV32I decode constants and immediate extraction for the issue stages.
package rv32i_pkg;

    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SRL  = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic {FMT_I, FMT_U} imm_fmt_e;

    typedef struct packed {
        logic [2:0]  funct3;
        logic        mod;
        logic        immediate;
        logic [31:0] val1;
        logic [31:0] val2;
        logic [4:0]  rd;
        logic        illegal;
    } alu_bundle_t;

    function automatic logic [31:0] imm_extract(input logic [31:0] instr, input imm_fmt_e fmt);
        logic signed [11:0] imm_i;
        logic signed [31:0] imm_i_ext;
        imm_i     = instr[31:20];
        imm_i_ext = imm_i;
        if (fmt == FMT_U)
            return {instr[31:12], 12'b0};
        return imm_i_ext;
    endfunction

endpackage

// File: rtl/issue_scoreboard.sv
// Register busy bitmap: one set port, one clear port, three read ports; x0 never busy.
module issue_scoreboard (
    input  logic       clk,
    input  logic       rst,
    input  logic       set_en,
    input  logic [4:0] set_idx,
    input  logic       clr_en,
    input  logic [4:0] clr_idx,
    input  logic [4:0] rd_idx1,
    input  logic [4:0] rd_idx2,
    input  logic [4:0] rd_idx3,
    output logic       busy1,
    output logic       busy2,
    output logic       busy3
);

    logic [31:0] busy;
    logic [31:0] busy_nxt;

    // Set is applied after clear so a coinciding set of the same bit wins.
    always_comb begin
        busy_nxt = busy;
        if (clr_en)
            busy_nxt[clr_idx] = 1'b0;
        if (set_en)
            busy_nxt[set_idx] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst)
            busy <= '0;
        else
            busy <= busy_nxt;
    end

    assign busy1 = busy[rd_idx1];
    assign busy2 = busy[rd_idx2];
    assign busy3 = busy[rd_idx3];

endmodule

// File: rtl/alu_issue.sv
// RV32I decode/issue stage: holds one instruction, reads operands, stalls on
// busy registers and presents a registered ALU operand bundle.
module alu_issue
    import rv32i_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter bit STALL_ON_WAW = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic [4:0]      rf_rs1_addr,
    output logic [4:0]      rf_rs2_addr,
    input  logic [XLEN-1:0] rf_rs1_data,
    input  logic [XLEN-1:0] rf_rs2_data,
    input  logic            wb_valid,
    input  logic [4:0]      wb_rd,
    output logic            alu_valid,
    input  logic            alu_ready,
    output logic [2:0]      alu_funct3,
    output logic            alu_mod,
    output logic            alu_immediate,
    output logic [XLEN-1:0] alu_val1,
    output logic [XLEN-1:0] alu_val2,
    output logic [4:0]      alu_rd,
    output logic            alu_illegal
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DECODE = 2'd1;
    localparam logic [1:0] S_HOLD   = 2'd2;

    logic [1:0]      state;
    logic [31:0]     instr_p0;
    logic [XLEN-1:0] pc_p0;
    alu_bundle_t     dec;
    alu_bundle_t     bundle_p1;

    logic [6:0] opcode, f7;
    logic [2:0] f3;
    logic       legal, use1, use2, wr;
    logic       busy1, busy2, busy3, hazard, set_en;

    assign opcode      = instr_p0[6:0];
    assign f3          = instr_p0[14:12];
    assign f7          = instr_p0[31:25];
    assign rf_rs1_addr = instr_p0[19:15];
    assign rf_rs2_addr = instr_p0[24:20];

    always_comb begin
        dec        = '0;
        dec.rd     = instr_p0[11:7];
        legal      = 1'b0;
        use1       = 1'b0;
        use2       = 1'b0;
        wr         = 1'b0;
        case (opcode)
            OP: begin
                legal = (f7 == F7_BASE) || (f7 == F7_ALT && (f3 == F3_ADD || f3 == F3_SRL));
                if (legal) begin
                    use1       = 1'b1;
                    use2       = 1'b1;
                    wr         = 1'b1;
                    dec.funct3 = f3;
                    dec.mod    = instr_p0[30];
                    dec.val1   = rf_rs1_data;
                    dec.val2   = rf_rs2_data;
                end
            end
            OP_IMM: begin
                if (f3 == F3_SLL)
                    legal = (f7 == F7_BASE);
                else if (f3 == F3_SRL)
                    legal = (f7 == F7_BASE) || (f7 == F7_ALT);
                else
                    legal = 1'b1;
                if (legal) begin
                    use1          = 1'b1;
                    wr            = 1'b1;
                    dec.funct3    = f3;
                    dec.mod       = (f3 == F3_SRL) ? instr_p0[30] : 1'b0;
                    dec.immediate = 1'b1;
                    dec.val1      = rf_rs1_data;
                    dec.val2      = imm_extract(instr_p0, FMT_I);
                end
            end
            LUI, AUIPC: begin
                legal         = 1'b1;
                wr            = 1'b1;
                dec.funct3    = F3_ADD;
                dec.immediate = 1'b1;
                dec.val1      = (opcode == AUIPC) ? pc_p0 : '0;
                dec.val2      = imm_extract(instr_p0, FMT_U);
            end
            default: legal = 1'b0;
        endcase
        dec.illegal = !legal;
    end

    // Illegal instructions never raise use/wr, so they bypass the hazard check.
    assign hazard = (use1 && busy1) || (use2 && busy2) || (STALL_ON_WAW && wr && busy3);
    assign set_en = (state == S_DECODE) && !hazard && legal && (dec.rd != 5'd0);

    issue_scoreboard u_sb (
        .clk     (clk),
        .rst     (rst),
        .set_en  (set_en),
        .set_idx (dec.rd),
        .clr_en  (wb_valid),
        .clr_idx (wb_rd),
        .rd_idx1 (rf_rs1_addr),
        .rd_idx2 (rf_rs2_addr),
        .rd_idx3 (dec.rd),
        .busy1   (busy1),
        .busy2   (busy2),
        .busy3   (busy3)
    );

    // Stage p0: capture the offered instruction
    always_ff @(posedge clk) begin
        if (in_valid && in_ready) begin
            instr_p0 <= in_instr;
            pc_p0    <= in_pc;
        end
    end

    // Stage p1: operand bundle held until execute accepts it
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            bundle_p1 <= '0;
        end else begin
            case (state)
                S_IDLE:   if (in_valid) state <= S_DECODE;
                S_DECODE: if (!hazard) begin
                    bundle_p1 <= dec;
                    state     <= S_HOLD;
                end
                S_HOLD:   if (alu_ready) state <= S_IDLE;
                default:  state <= S_IDLE;
            endcase
        end
    end

    assign in_ready      = (state == S_IDLE) && !rst;
    assign alu_valid     = (state == S_HOLD);
    assign alu_funct3    = bundle_p1.funct3;
    assign alu_mod       = bundle_p1.mod;
    assign alu_immediate = bundle_p1.immediate;
    assign alu_val1      = bundle_p1.val1;
    assign alu_val2      = bundle_p1.val2;
    assign alu_rd        = bundle_p1.rd;
    assign alu_illegal   = bundle_p1.illegal;

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue: expected bundles queued at issue, checked by a monitor.
module tb_alu_issue;

    typedef struct packed {
        logic [2:0]  f3;
        logic        mod;
        logic        imm;
        logic [31:0] v1;
        logic [31:0] v2;
        logic [4:0]  rd;
        logic        ill;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic [4:0]  rf_rs1_addr, rf_rs2_addr;
    logic [31:0] rf_rs1_data, rf_rs2_data;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        alu_valid;
    logic        alu_ready;
    logic [2:0]  alu_funct3;
    logic        alu_mod, alu_immediate, alu_illegal;
    logic [31:0] alu_val1, alu_val2;
    logic [4:0]  alu_rd;

    logic [31:0] rf [32];
    exp_t        expq[$];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    assign rf_rs1_data = rf[rf_rs1_addr];
    assign rf_rs2_data = rf[rf_rs2_addr];

    alu_issue #(.XLEN(32), .STALL_ON_WAW(1'b1)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_instr      (in_instr),
        .in_pc         (in_pc),
        .rf_rs1_addr   (rf_rs1_addr),
        .rf_rs2_addr   (rf_rs2_addr),
        .rf_rs1_data   (rf_rs1_data),
        .rf_rs2_data   (rf_rs2_data),
        .wb_valid      (wb_valid),
        .wb_rd         (wb_rd),
        .alu_valid     (alu_valid),
        .alu_ready     (alu_ready),
        .alu_funct3    (alu_funct3),
        .alu_mod       (alu_mod),
        .alu_immediate (alu_immediate),
        .alu_val1      (alu_val1),
        .alu_val2      (alu_val2),
        .alu_rd        (alu_rd),
        .alu_illegal   (alu_illegal)
    );

    function automatic exp_t mk(input logic [2:0] f3, input logic m, input logic im,
                                input logic [31:0] v1, input logic [31:0] v2,
                                input logic [4:0] rd, input logic ill);
        exp_t e;
        e = '{f3: f3, mod: m, imm: im, v1: v1, v2: v2, rd: rd, ill: ill};
        return e;
    endfunction

    function automatic exp_t actual();
        exp_t a;
        a = '{f3: alu_funct3, mod: alu_mod, imm: alu_immediate, v1: alu_val1,
              v2: alu_val2, rd: alu_rd, ill: alu_illegal};
        return a;
    endfunction

    task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Monitor: compare every accepted bundle against the oldest expectation
    always @(negedge clk) begin
        if (!rst && alu_valid && alu_ready) begin
            if (expq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_bundle actual=%h required=none", actual());
            end else begin
                chk("bundle", 80'(actual()), 80'(expq.pop_front()));
            end
        end
    end

    task automatic issue(input logic [31:0] instr, input logic [31:0] pc);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout actual=in_ready0 required=in_ready1");
        end
        in_valid = 1'b1;
        in_instr = instr;
        in_pc    = pc;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((expq.size() != 0 || !in_ready) && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (expq.size() != 0 || !in_ready) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout actual=%0d pending required=0", expq.size());
            expq.delete();
        end
    endtask

    task automatic wb(input logic [4:0] r);
        wb_valid = 1'b1;
        wb_rd    = r;
        @(posedge clk); #1;
        wb_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t ex;
        for (int i = 0; i < 32; i++) rf[i] = 32'h0;
        rf[1] = 32'd10;
        rf[2] = 32'd3;
        rst = 1'b1; in_valid = 1'b0; in_instr = '0; in_pc = '0;
        wb_valid = 1'b0; wb_rd = '0; alu_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 80'(in_ready), 80'd0);
        chk("rst_alu_valid", 80'(alu_valid), 80'd0);
        chk("rst_bundle", 80'(actual()), 80'd0);
        chk("rst_busy", 80'(dut.u_sb.busy), 80'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("idle_in_ready", 80'(in_ready), 80'd1);

        // ADDI x1,x0,5 with latency checks
        expq.push_back(mk(3'b000, 0, 1, 32'd0, 32'd5, 5'd1, 0));
        issue(32'h00500093, 32'h0);
        chk("addi_decode_valid", 80'(alu_valid), 80'd0);
        @(posedge clk); #1;
        chk("addi_valid", 80'(alu_valid), 80'd1);
        @(posedge clk); #1;
        chk("addi_busy", 80'(dut.u_sb.busy), 80'h2);
        chk("addi_back_idle", 80'(in_ready), 80'd1);
        wb(5'd1);
        chk("wb_clear_busy", 80'(dut.u_sb.busy), 80'd0);

        // SUB x3,x1,x2
        expq.push_back(mk(3'b000, 1, 0, 32'd10, 32'd3, 5'd3, 0));
        issue(32'h402081B3, 32'h4);
        drain();
        chk("sub_busy", 80'(dut.u_sb.busy), 80'h8);
        wb(5'd3);

        // SRAI x5,x1,3
        expq.push_back(mk(3'b101, 1, 1, 32'd10, 32'h00000403, 5'd5, 0));
        issue(32'h4030D293, 32'h8);
        drain();
        wb(5'd5);

        // LUI x7,0x12345
        expq.push_back(mk(3'b000, 0, 1, 32'd0, 32'h12345000, 5'd7, 0));
        issue(32'h123453B7, 32'h40);
        drain();
        wb(5'd7);

        // AUIPC x8,0x1 at pc 0x100
        expq.push_back(mk(3'b000, 0, 1, 32'h100, 32'h1000, 5'd8, 0));
        issue(32'h00001417, 32'h100);
        drain();
        wb(5'd8);
        chk("busy_all_clear", 80'(dut.u_sb.busy), 80'd0);

        // RAW hazard: ADD x2,x1,x1 waits for writeback of x1
        expq.push_back(mk(3'b000, 0, 1, 32'd0, 32'd5, 5'd1, 0));
        issue(32'h00500093, 32'h0);
        drain();
        expq.push_back(mk(3'b000, 0, 0, 32'd10, 32'd10, 5'd2, 0));
        issue(32'h00108133, 32'h4);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("haz_stall_valid", 80'(alu_valid), 80'd0);
        end
        wb_valid = 1'b1;
        wb_rd    = 5'd1;
        @(posedge clk); #1;
        wb_valid = 1'b0;
        chk("haz_wb_edge_valid", 80'(alu_valid), 80'd0);
        @(posedge clk); #1;
        chk("haz_release_valid", 80'(alu_valid), 80'd1);
        drain();
        chk("haz_busy", 80'(dut.u_sb.busy), 80'h4);
        wb(5'd2);

        // Backpressure: XOR x4,x1,x2 held for 5 cycles
        alu_ready = 1'b0;
        ex = mk(3'b100, 0, 0, 32'd10, 32'd3, 5'd4, 0);
        expq.push_back(ex);
        issue(32'h0020C233, 32'h8);
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp_valid", 80'(alu_valid), 80'd1);
            chk("bp_in_ready", 80'(in_ready), 80'd0);
            chk("bp_bundle", 80'(actual()), 80'(ex));
        end
        alu_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_in_ready", 80'(in_ready), 80'd1);
        chk("bp_release_valid", 80'(alu_valid), 80'd0);
        wb(5'd4);

        // Illegal: ECALL, then SLLI with bad funct7 while x1 is busy
        expq.push_back(mk(3'b000, 0, 0, 32'd0, 32'd0, 5'd0, 1));
        issue(32'h00000073, 32'h0);
        drain();
        chk("ecall_busy", 80'(dut.u_sb.busy), 80'd0);
        expq.push_back(mk(3'b000, 0, 1, 32'd0, 32'd5, 5'd1, 0));
        issue(32'h00500093, 32'h0);
        drain();
        expq.push_back(mk(3'b000, 0, 0, 32'd0, 32'd0, 5'd1, 1));
        issue(32'h40109093, 32'h4);
        drain();
        chk("illegal_busy", 80'(dut.u_sb.busy), 80'h2);

        // Reset while stalled in DECODE
        issue(32'h00108133, 32'h8);
        @(posedge clk); #1;
        chk("rstdec_stalled", 80'({alu_valid, in_ready}), 80'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rstdec_valid", 80'(alu_valid), 80'd0);
        chk("rstdec_busy", 80'(dut.u_sb.busy), 80'd0);
        chk("rstdec_in_ready", 80'(in_ready), 80'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rstdec_idle", 80'(in_ready), 80'd1);
        chk("rstdec_valid_after", 80'(alu_valid), 80'd0);

        expq.push_back(mk(3'b000, 0, 1, 32'd0, 32'd5, 5'd1, 0));
        issue(32'h00500093, 32'h0);
        drain();
        wb(5'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
